wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//   Write-back stage directly upstream of the 32x32 register file; drives its write port (Din/WE/WR).
//   Merges two result sources onto that single write port:
//   - main-pipeline results: always accepted, top priority;
//   - long-latency unit results (mul/div, loads): valid/ready interface, buffered in a small FIFO.
//   Keeps a per-register busy scoreboard so decode stalls on operands still in flight.
// PARAMETERS
//   DEPTH  2  long-result FIFO entries; power of two, >=2
//   AW     1  FIFO pointer width = $clog2(DEPTH)
// PORTS
//   clk        in   1   single clock; all state updates on posedge
//   rst        in   1   synchronous, active-high reset
//   pipe_we    in   1   main-pipeline write request this cycle
//   pipe_wr    in   5   main-pipeline destination register
//   pipe_din   in   32  main-pipeline result
//   lng_valid  in   1   long-unit result valid
//   lng_wr     in   5   long-unit destination register
//   lng_din    in   32  long-unit result
//   lng_ready  out  1   FIFO can accept; = !full, forced 0 while rst=1
//   iss_valid  in   1   long op issued this cycle (marks dest busy)
//   iss_wr     in   5   destination register of the issued long op
//   rd_r1      in   5   decode read address 1 (same as regfile R1)
//   rd_r2      in   5   decode read address 2 (same as regfile R2)
//   r1_busy    out  1   rd_r1 has a long write outstanding (combinational)
//   r2_busy    out  1   rd_r2 has a long write outstanding (combinational)
//   wb_we      out  1   regfile WE (registered)
//   wb_wr      out  5   regfile WR (registered)
//   wb_din     out  32  regfile Din (registered)
// BEHAVIOUR
//   Reset: wb_we=0, wb_wr=0, wb_din=0, FIFO empty, busy[31:0]=0, lng_ready=0 during rst, 1 the cycle after.
//   Push: lng_valid && lng_ready writes {lng_wr, lng_din} to the FIFO tail.
//     - No push when full, even if a pop occurs in the same cycle.
//   Selection each cycle, registered into wb_* at the next posedge (latency 1):
//     - pipe_we=1: pipe result selected; FIFO does not pop.
//     - else FIFO non-empty: head popped and selected.
//     - else wb_we=0 next cycle; wb_wr and wb_din hold their values.
//   r0 rule: a selected write with wr=0 yields wb_we=0. A FIFO head with wr=0 is still popped (discarded).
//   pipe_we=1 with pipe_wr=0 counts as a pipe slot: the FIFO waits that cycle.
//   Ordering: FIFO strictly in order; pipe writes may overtake buffered long results.
//   Timing: regfile writes on negedge, so a value on wb_* in cycle N is readable at the posedge ending N.
//   Scoreboard (busy[31:1]; busy[0] always 0):
//     - set on iss_valid && iss_wr!=0;
//     - cleared at the posedge that loads a popped FIFO entry for that register into wb_*.
//     - Same reg set and cleared in one cycle: set wins.
//     - Issue logic never issues a second long op to a busy register; the bench asserts this.
//   r1_busy = busy[rd_r1]; r2_busy = busy[rd_r2]; both 0 for address 0.
//   Mid-operation reset: FIFO contents and busy bits are discarded; no write emitted after rst.
// CONFIGURATION
//   WB_SCOREBOARD_EN defined:
//     - busy array, iss_* inputs and r1_busy/r2_busy as described above.
//   WB_SCOREBOARD_EN undefined:
//     - no busy storage; iss_* ignored; r1_busy=r2_busy=0;
//     - arbitration and FIFO unchanged.
// TESTING
//   1. rst=1 for 2 cycles -> wb_we=0, wb_wr=0, wb_din=0, lng_ready=0; after release lng_ready=1, r1_busy=0.
//   2. pipe_we=1, pipe_wr=5, pipe_din=32'h1234 in cycle N -> cycle N+1: wb_we=1, wb_wr=5, wb_din=32'h1234.
//   3. lng push wr=7, din=32'hAA while pipe_we=1 for 3 cycles
//      -> no lng write while pipe_we=1; wb_we=1, wb_wr=7, wb_din=32'hAA the cycle after pipe_we drops.
//   4. pipe_we held 1; push wr=3 then wr=4
//      -> lng_ready=0 after the 2nd push; on pipe idle, writes reg3 then reg4 on consecutive cycles;
//      -> lng_ready=1 again after the first pop.
//   5. iss_valid, iss_wr=9; rd_r1=9 -> r1_busy=1 next cycle; lng push wr=9 with pipe idle
//      -> r1_busy=0 in the cycle wb_wr=9, wb_we=1. (Macro off: r1_busy stays 0.)
//   6. pipe_we=1, pipe_wr=0, then FIFO head wr=0
//      -> wb_we=0 both cycles; FIFO empty afterwards; busy[0]=0.

Source files
------------

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_if
// Description : Bundle of pipe, long-unit, issue, decode-read and regfile
//               write-port signals around the write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_wr;
    logic [31:0] pipe_din;
    logic        lng_valid;
    logic [4:0]  lng_wr;
    logic [31:0] lng_din;
    logic        lng_ready;
    logic        iss_valid;
    logic [4:0]  iss_wr;
    logic [4:0]  rd_r1;
    logic [4:0]  rd_r2;
    logic        r1_busy;
    logic        r2_busy;
    logic        wb_we;
    logic [4:0]  wb_wr;
    logic [31:0] wb_din;

    // Arbiter side
    modport slave (
        input  pipe_we, pipe_wr, pipe_din,
        input  lng_valid, lng_wr, lng_din,
        input  iss_valid, iss_wr, rd_r1, rd_r2,
        output lng_ready, r1_busy, r2_busy,
        output wb_we, wb_wr, wb_din
    );

    // Pipeline / long-unit / decode side
    modport master (
        output pipe_we, pipe_wr, pipe_din,
        output lng_valid, lng_wr, lng_din,
        output iss_valid, iss_wr, rd_r1, rd_r2,
        input  lng_ready, r1_busy, r2_busy,
        input  wb_we, wb_wr, wb_din
    );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Register-file write-back arbiter: pipe results take priority,
//               long-unit results queue in a FIFO. Optional busy scoreboard
//               enabled by defining WB_SCOREBOARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic     clk,
    input  wire logic     rst,
    wb_arbiter_if.slave   bus
);
    localparam int c_ENTRY_W = 37;

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW:0]          r_wptr;
    logic [AW:0]          r_rptr;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_ready;
    logic                 w_push;
    logic                 w_pop;
    logic [4:0]           w_head_wr;
    logic [31:0]          w_head_din;
    logic                 r_wb_we;
    logic [4:0]           r_wb_wr;
    logic [31:0]          r_wb_din;

    // Extra pointer bit separates full from empty when the indices match
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) &&
                        (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_ready    = !w_full && !rst;
    assign w_push     = bus.lng_valid && w_ready;
    assign w_pop      = !bus.pipe_we && !w_empty;
    assign {w_head_wr, w_head_din} = r_mem[r_rptr[AW-1:0]];

    assign bus.lng_ready = w_ready;
    assign bus.wb_we     = r_wb_we;
    assign bus.wb_wr     = r_wb_wr;
    assign bus.wb_din    = r_wb_din;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {bus.lng_wr, bus.lng_din};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Writes to r0 still occupy the slot (and pop the FIFO) but never assert WE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_we  <= 1'b0;
            r_wb_wr  <= 5'd0;
            r_wb_din <= 32'd0;
        end else if (bus.pipe_we) begin
            r_wb_we  <= (bus.pipe_wr != 5'd0);
            r_wb_wr  <= bus.pipe_wr;
            r_wb_din <= bus.pipe_din;
        end else if (w_pop) begin
            r_wb_we  <= (w_head_wr != 5'd0);
            r_wb_wr  <= w_head_wr;
            r_wb_din <= w_head_din;
        end else begin
            r_wb_we  <= 1'b0;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:0] r_busy;
    logic [31:0] w_busy_nxt;

    // Set is applied after clear so a same-cycle issue wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop)         w_busy_nxt[w_head_wr]  = 1'b0;
        if (bus.iss_valid) w_busy_nxt[bus.iss_wr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end

    assign bus.r1_busy = r_busy[bus.rd_r1];
    assign bus.r2_busy = r_busy[bus.rd_r2];
`else
    logic w_unused_sb;
    assign w_unused_sb = ^{bus.iss_valid, bus.iss_wr, bus.rd_r1, bus.rd_r2};
    assign bus.r1_busy = 1'b0;
    assign bus.r2_busy = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Directed self-checking bench for wb_arbiter with a queue-based
//               reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
`ifdef WB_SCOREBOARD_EN
    localparam bit c_SB = 1'b1;
`else
    localparam bit c_SB = 1'b0;
`endif
    localparam int c_DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if bus();

    wb_arbiter #(.DEPTH(c_DEPTH), .AW(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: entries waiting for the write port, plus outstanding dests
    typedef struct { logic [4:0] wr; logic [31:0] din; } ent_t;
    ent_t        q[$];
    bit   [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_wr;
    logic [31:0] m_din;
    bit          started = 1'b0;

    always @(posedge clk) begin
        bit   acc;
        ent_t e;
        started = 1'b1;
        if (bus.iss_valid && bus.iss_wr != 5'd0 && m_busy[bus.iss_wr])
            $error("illegal stimulus: issue to busy register %0d", bus.iss_wr);
        if (rst) begin
            q.delete();
            m_busy = '0;
            m_we = 1'b0; m_wr = 5'd0; m_din = 32'd0;
        end else begin
            acc = bus.lng_valid && (q.size() < c_DEPTH);
            if (bus.pipe_we) begin
                m_we = (bus.pipe_wr != 0); m_wr = bus.pipe_wr; m_din = bus.pipe_din;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                m_we = (e.wr != 0); m_wr = e.wr; m_din = e.din;
                m_busy[e.wr] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (acc) begin
                e.wr = bus.lng_wr; e.din = bus.lng_din;
                q.push_back(e);
            end
            if (bus.iss_valid && bus.iss_wr != 0) m_busy[bus.iss_wr] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_ready", 32'(bus.lng_ready), 32'(!rst && q.size() < c_DEPTH));
            chk("m_we",    32'(bus.wb_we), 32'(m_we));
            if (m_we) begin
                chk("m_wr",  32'(bus.wb_wr), 32'(m_wr));
                chk("m_din", bus.wb_din, m_din);
            end
            chk("m_r1busy", 32'(bus.r1_busy), 32'(c_SB && m_busy[bus.rd_r1]));
            chk("m_r2busy", 32'(bus.r2_busy), 32'(c_SB && m_busy[bus.rd_r2]));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic wbchk(input string name, input logic we, input logic [4:0] wr, input logic [31:0] din);
        chk({name, "_we"}, 32'(bus.wb_we), 32'(we));
        chk({name, "_wr"}, 32'(bus.wb_wr), 32'(wr));
        chk({name, "_din"}, bus.wb_din, din);
    endtask

    initial begin
        bus.pipe_we = 0; bus.pipe_wr = 0; bus.pipe_din = 0;
        bus.lng_valid = 0; bus.lng_wr = 0; bus.lng_din = 0;
        bus.iss_valid = 0; bus.iss_wr = 0; bus.rd_r1 = 0; bus.rd_r2 = 0;

        // Reset
        rst = 1; tick(); tick();
        wbchk("rst", 0, 0, 0);
        chk("rst_ready", 32'(bus.lng_ready), 0);
        rst = 0; bus.rd_r1 = 5'd9; tick();
        chk("post_rst_ready", 32'(bus.lng_ready), 1);
        chk("post_rst_r1busy", 32'(bus.r1_busy), 0);

        // Single pipe write
        bus.pipe_we = 1; bus.pipe_wr = 5; bus.pipe_din = 32'h1234; tick();
        wbchk("pipe", 1, 5, 32'h1234);

        // Long push held off by three pipe cycles
        bus.pipe_wr = 1; bus.pipe_din = 32'h1111;
        bus.lng_valid = 1; bus.lng_wr = 7; bus.lng_din = 32'hAA; tick();
        bus.lng_valid = 0;
        wbchk("hold1", 1, 1, 32'h1111);
        tick(); tick();
        wbchk("hold3", 1, 1, 32'h1111);
        bus.pipe_we = 0; tick();
        wbchk("lng7", 1, 7, 32'hAA);
        tick();
        wbchk("idle_hold", 0, 7, 32'hAA);

        // Fill FIFO behind pipe, then refuse a push while full even as it pops
        bus.pipe_we = 1; bus.pipe_wr = 2; bus.pipe_din = 32'h22;
        bus.lng_valid = 1; bus.lng_wr = 3; bus.lng_din = 32'h33; tick();
        chk("one_ready", 32'(bus.lng_ready), 1);
        bus.lng_wr = 4; bus.lng_din = 32'h44; tick();
        chk("full_ready", 32'(bus.lng_ready), 0);
        bus.pipe_we = 0; bus.lng_wr = 5; bus.lng_din = 32'h55; tick();
        wbchk("pop3", 1, 3, 32'h33);
        chk("pop3_ready", 32'(bus.lng_ready), 1);
        tick();
        bus.lng_valid = 0;
        wbchk("pop4", 1, 4, 32'h44);
        tick();
        wbchk("pop5", 1, 5, 32'h55);
        tick();
        chk("drained_we", 32'(bus.wb_we), 0);

        // Scoreboard set by issue, cleared when the long result is written
        bus.iss_valid = 1; bus.iss_wr = 9; bus.rd_r1 = 9; tick();
        bus.iss_valid = 0;
        chk("busy9_set", 32'(bus.r1_busy), 32'(c_SB));
        bus.lng_valid = 1; bus.lng_wr = 9; bus.lng_din = 32'h99; tick();
        bus.lng_valid = 0;
        chk("busy9_queued", 32'(bus.r1_busy), 32'(c_SB));
        tick();
        wbchk("wb9", 1, 9, 32'h99);
        chk("busy9_clr", 32'(bus.r1_busy), 0);

        // Same-cycle clear and set of one register: set wins
        bus.rd_r2 = 12;
        bus.lng_valid = 1; bus.lng_wr = 12; bus.lng_din = 32'hC; tick();
        bus.lng_valid = 0; bus.iss_valid = 1; bus.iss_wr = 12; tick();
        bus.iss_valid = 0;
        wbchk("wb12", 1, 12, 32'hC);
        chk("busy12_setwins", 32'(bus.r2_busy), 32'(c_SB));
        bus.lng_valid = 1; bus.lng_din = 32'hCC; tick();
        bus.lng_valid = 0; tick();
        chk("busy12_clr", 32'(bus.r2_busy), 0);

        // r0 writes from both sources are swallowed
        bus.rd_r1 = 0; bus.rd_r2 = 0;
        bus.pipe_we = 1; bus.pipe_wr = 0; bus.pipe_din = 32'hDEAD;
        bus.lng_valid = 1; bus.lng_wr = 0; bus.lng_din = 32'hBEEF;
        bus.iss_valid = 1; bus.iss_wr = 0; tick();
        bus.pipe_we = 0; bus.lng_valid = 0; bus.iss_valid = 0;
        chk("r0_pipe_we", 32'(bus.wb_we), 0);
        tick();
        chk("r0_lng_we", 32'(bus.wb_we), 0);
        tick();
        chk("r0_empty_we", 32'(bus.wb_we), 0);
        chk("r0_ready", 32'(bus.lng_ready), 1);
        chk("r0_busy", 32'(bus.r1_busy), 0);

        // Reset mid-operation discards queued results and busy bits
        bus.rd_r1 = 20;
        bus.pipe_we = 1; bus.pipe_wr = 1; bus.pipe_din = 32'h1;
        bus.iss_valid = 1; bus.iss_wr = 20;
        bus.lng_valid = 1; bus.lng_wr = 20; bus.lng_din = 32'h20; tick();
        bus.iss_valid = 0; bus.lng_wr = 21; bus.lng_din = 32'h21; tick();
        chk("pre_rst_busy", 32'(bus.r1_busy), 32'(c_SB));
        rst = 1; bus.pipe_we = 0; bus.lng_valid = 0; tick();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_mid_rst_we", 32'(bus.wb_we), 0);
        end
        chk("post_mid_rst_busy", 32'(bus.r1_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
